// File: rtl/serial_bcd_addsub_controller.sv
// serial_bcd_addsub_controller: digit-serial BCD add/subtract with sign-magnitude result.
// One shared BCD digit slice; subtraction uses 9's complement plus a recomplement pass when negative.
module serial_bcd_addsub_controller #(
    parameter int DIGITS = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Mode,
    input  logic [4*DIGITS-1:0] A,
    input  logic [4*DIGITS-1:0] B,
    output logic                Busy,
    output logic                Done,
    output logic [4*DIGITS-1:0] Result,
    output logic                Carry_Out,
    output logic                Negative,
    output logic                Invalid
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          mode_q, mode_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d, neg_q, neg_d, inv_q, inv_d;
    logic          bad, last, sc;
    logic [3:0]    x, y, bd, rd, sd;
    logic [4:0]    s;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | (A[4*i +: 4] > 4'd9) | (B[4*i +: 4] > 4'd9);
    end

    // Shared slice: FIX feeds 9's complement of the working result digit with X = 0
    assign bd   = b_q[{idx_q, 2'b00} +: 4];
    assign rd   = res_q[{idx_q, 2'b00} +: 4];
    assign x    = state_q == FIX ? 4'd0 : a_q[{idx_q, 2'b00} +: 4];
    assign y    = state_q == FIX ? 4'd9 - rd : mode_q ? 4'd9 - bd : bd;
    assign s    = {1'b0, x} + {1'b0, y} + {4'd0, carry_q};
    assign sc   = s > 5'd9;
    assign sd   = sc ? s[3:0] + 4'd6 : s[3:0];
    assign last = idx_q == IW'(DIGITS - 1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        result_d = result_q;
        cout_d   = cout_q;
        neg_d    = neg_q;
        inv_d    = inv_q;
        case (state_q)
            IDLE: if (Start) begin
                a_d     = A;
                b_d     = B;
                mode_d  = Mode;
                idx_d   = '0;
                carry_d = Mode;
                res_d   = '0;
                state_d = bad ? DONE : ADD;
                if (bad) begin
                    result_d = '0;
                    cout_d   = 1'b0;
                    neg_d    = 1'b0;
                    inv_d    = 1'b1;
                end
            end
            ADD: begin
                res_d[{idx_q, 2'b00} +: 4] = sd;
                carry_d = sc;
                idx_d   = last ? '0 : idx_q + 1'b1;
                if (last && (!mode_q || sc)) begin
                    state_d  = DONE;
                    result_d = res_d;
                    cout_d   = sc;
                    neg_d    = 1'b0;
                    inv_d    = 1'b0;
                end else if (last) begin
                    state_d = FIX;
                    carry_d = 1'b1;
                end
            end
            FIX: begin
                res_d[{idx_q, 2'b00} +: 4] = sd;
                carry_d = sc;
                idx_d   = last ? '0 : idx_q + 1'b1;
                if (last) begin
                    state_d  = DONE;
                    result_d = res_d;
                    cout_d   = 1'b0;
                    neg_d    = 1'b1;
                    inv_d    = 1'b0;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            neg_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            neg_q    <= neg_d;
            inv_q    <= inv_d;
        end
    end

    assign Busy      = state_q == ADD || state_q == FIX;
    assign Done      = state_q == DONE;
    assign Result    = result_q;
    assign Carry_Out = cout_q;
    assign Negative  = neg_q;
    assign Invalid   = inv_q;
endmodule

// File: tb/tb_serial_bcd_addsub_controller.sv
// tb_serial_bcd_addsub_controller: table vectors, multi-cycle corner sequences and
// random commands checked against an integer-arithmetic reference model.
module tb_serial_bcd_addsub_controller;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst, start, mode, busy, done, cout, neg, inv;
    logic [4*D-1:0] a, b, result;
    int            n_cmp = 0, n_err = 0;

    serial_bcd_addsub_controller #(.DIGITS(D)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .Mode(mode), .A(a), .B(b),
        .Busy(busy), .Done(done), .Result(result), .Carry_Out(cout),
        .Negative(neg), .Invalid(inv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic [15:0] a, b, r;
        logic        c, n, v;
        int          lat;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int x);
        logic [15:0] r;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic vec_t ref_model(input logic m, input logic [15:0] av, input logic [15:0] bv);
        vec_t e;
        int   x, y;
        logic bad = 1'b0;
        e.m = m; e.a = av; e.b = bv;
        for (int i = 0; i < D; i++) bad = bad | (av[4*i +: 4] > 9) | (bv[4*i +: 4] > 9);
        x = bcd2int(av);
        y = bcd2int(bv);
        if (bad) begin
            e.r = 0; e.c = 0; e.n = 0; e.v = 1; e.lat = 1;
        end else if (!m) begin
            e.r = int2bcd((x + y) % (10 ** D)); e.c = (x + y) >= 10 ** D; e.n = 0; e.v = 0; e.lat = D + 1;
        end else if (x >= y) begin
            e.r = int2bcd(x - y); e.c = 1; e.n = 0; e.v = 0; e.lat = D + 1;
        end else begin
            e.r = int2bcd(y - x); e.c = 0; e.n = 1; e.v = 0; e.lat = 2 * D + 1;
        end
        return e;
    endfunction

    // Called at posedge+1 in IDLE; returns at posedge+1 of the cycle after Done.
    task automatic run_cmd(input vec_t e, input string nm);
        logic [15:0] prev = result;
        int          lat = 1, bc = 0;
        logic        hold = 1'b1;
        start = 1'b1; mode = e.m; a = e.a; b = e.b;
        @(posedge clk); #1;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        while (!done && lat < 40) begin
            bc += int'(busy);
            if (result !== prev) hold = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, e.lat);
        chk({nm, " result"}, result, e.r);
        chk({nm, " carry"}, cout, e.c);
        chk({nm, " negative"}, neg, e.n);
        chk({nm, " invalid"}, inv, e.v);
        chk({nm, " busy_cycles"}, bc, e.lat - 1);
        chk({nm, " busy_in_done"}, busy, 0);
        chk({nm, " hold"}, hold, 1);
        @(posedge clk); #1;
        chk({nm, " done_pulse"}, done, 0);
    endtask

    initial begin
        int          dn;
        logic [15:0] ra, rb;
        tv[0]  = '{0, 16'h1234, 16'h5678, 16'h6912, 0, 0, 0, 5};
        tv[1]  = '{0, 16'h9999, 16'h0001, 16'h0000, 1, 0, 0, 5};
        tv[2]  = '{0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 5};
        tv[3]  = '{1, 16'h5000, 16'h1234, 16'h3766, 1, 0, 0, 5};
        tv[4]  = '{1, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0, 5};
        tv[5]  = '{1, 16'h0123, 16'h0456, 16'h0333, 0, 1, 0, 9};
        tv[6]  = '{0, 16'h12A4, 16'h0001, 16'h0000, 0, 0, 1, 1};
        tv[7]  = '{0, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 5};
        tv[8]  = '{1, 16'h0000, 16'h9999, 16'h9999, 0, 1, 0, 9};
        tv[9]  = '{1, 16'h0000, 16'h000F, 16'h0000, 0, 0, 1, 1};
        tv[10] = '{1, 16'h9999, 16'h0000, 16'h9999, 1, 0, 0, 5};
        tv[11] = '{0, 16'h0500, 16'h0500, 16'h1000, 0, 0, 0, 5};
        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {busy, done, cout, neg, inv, result}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) run_cmd(tv[i], $sformatf("vec%0d", i));

        // Reset during the second ADD cycle aborts with no Done
        start = 1'b1; mode = 1'b0; a = 16'h1234; b = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset outputs", {busy, done, cout, neg, inv, result}, 0);
        dn = 0;
        repeat (12) begin
            @(posedge clk); #1;
            dn += int'(done);
        end
        chk("midreset no_done", dn, 0);

        // Start held high through Busy and DONE must not queue a second command
        start = 1'b1; mode = 1'b0; a = 16'h1111; b = 16'h2222;
        dn = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin a = 16'h9999; b = 16'h9999; end
            if (k == 5) start = 1'b0;
            dn += int'(done);
            if (done) chk("busy_start result", result, 16'h3333);
        end
        chk("busy_start done_count", dn, 1);

        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < D; j++) begin
                ra[4*j +: 4] = $urandom_range(0, 24) == 0 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                rb[4*j +: 4] = $urandom_range(0, 24) == 0 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            run_cmd(ref_model(1'($urandom_range(0, 1)), ra, rb), $sformatf("rnd%0d", i));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
